inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Fetch stage upstream of op_decode in the 8-bit CPU. Owns the program counter,
//  addresses the synchronous program ROM and latches the instruction register.
//  Presents op to op_decode and imm to the datapath. Applies jumps and halt
//  requests from the execute/flag logic.
// PARAMETERS
//  PC_W      8   program counter / ROM address width
//  OP_W      4   opcode field width (op_decode input)
//  IMM_W     8   immediate field width; ROM word = OP_W+IMM_W bits
//  RESET_PC  0   PC value loaded on reset
// PORTS
//  clk         in   1            system clock, rising edge
//  rst         in   1            asynchronous reset, active high
//  en          in   1            step enable; all state advances only when en=1
//  rom_addr    out  PC_W         ROM address, = pc at all times
//  rom_data    in   OP_W+IMM_W   ROM word, valid 1 clk after rom_addr is stable
//  jmp         in   1            take jump at end of current EXEC
//  jmp_addr    in   PC_W         jump target
//  halt        in   1            stop fetching at end of current EXEC
//  op          out  OP_W         ir[OP_W+IMM_W-1:IMM_W], to op_decode
//  imm         out  IMM_W        ir[IMM_W-1:0]
//  pc          out  PC_W         address of the instruction in ir while in EXEC
//  inst_valid  out  1            1 only in EXEC: op/imm are the live instruction
//  halted      out  1            1 in HALT
// BEHAVIOUR
//  Reset: rst=1 takes effect immediately, no clock needed. pc=RESET_PC,
//   ir=0 (op=0, imm=0), state=ADDR, inst_valid=0, halted=0. Applies in any state.
//  FSM (2-bit state, transitions only on clk edges with en=1):
//   ADDR -> WAIT: the ROM samples rom_addr=pc on this edge.
//   WAIT -> EXEC: ir <= rom_data.
//   EXEC -> HALT if halt=1. pc is not changed, halt has priority over jmp.
//   EXEC -> ADDR if halt=0: pc <= jmp ? jmp_addr : pc+1.
//    pc+1 wraps modulo 2**PC_W, so 8'hFF -> 8'h00.
//   HALT -> HALT: only rst leaves HALT.
//  Latency: 3 enabled cycles per instruction. op/imm hold during ADDR/WAIT of the
//   next fetch and change only on the WAIT->EXEC edge.
//  en=0: state, pc and ir hold in every state. The ROM address is unchanged, so
//   rom_data remains valid through a WAIT stall.
//  jmp and halt are sampled only on the EXEC edge with en=1 and are ignored
//   otherwise. jmp to the current pc is legal and gives a self-loop.
//  inst_valid = (state==EXEC). halted = (state==HALT). Both are decoded from
//   registered state, with no combinational path from inputs.
//  rom_addr equals pc, registered. No path from jmp_addr to rom_addr in the
//   same cycle.
//  Reset mid-WAIT discards the in-flight ROM word. The first fetch after
//   release is from RESET_PC.
// STRUCTURE
//  Shared header cpu_defs.vh: OP_W, IMM_W, PC_W, and the state encodings
//   ADDR=0, WAIT=1, EXEC=2, HALT=3.
//  Sub-module pc_reg holds the PC register, async reset to RESET_PC, a load
//   port and an increment port. The load port takes priority.
//  inst_fetch contains the FSM, the ir register and the field split.
// TESTING
//  1. Reset, then en=1, ROM[0]=12'h3_A5 -> edge 2: op=3, imm=A5, inst_valid=1,
//     pc=0. Edge 3: rom_addr=1.
//  2. Free run on ROM[0..3] -> inst_valid pulses every 3rd cycle with
//     op=ROM[n][11:8].
//  3. In EXEC at pc=5, jmp=1, jmp_addr=8'h40 -> rom_addr=40 next cycle and the
//     next op comes from ROM[40]. jmp asserted in ADDR or WAIT has no effect.
//  4. pc=FF in EXEC, no jmp -> pc=00. halt=1 with jmp=1 -> halted=1, pc stays,
//     state stays in HALT for 20 cycles.
//  5. en toggled 0/1 randomly -> same op sequence as test 2, and nothing
//     changes while en=0.
//  6. rst pulsed asynchronously between edges while in WAIT -> outputs are at
//     reset values immediately, and the refetch starts from ROM[0].

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared widths and fetch FSM state encoding
package inst_fetch_pkg;
  localparam int PC_W  = 8;
  localparam int OP_W  = 4;
  localparam int IMM_W = 8;
  localparam int ROM_W = OP_W + IMM_W;
  typedef enum logic [1:0] {
    ADDR = 2'd0,
    WAIT = 2'd1,
    EXEC = 2'd2,
    HALT = 2'd3
  } state_t;
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: ROM bus, control inputs and decoded-instruction outputs of the fetch stage
interface inst_fetch_if;
  import inst_fetch_pkg::*;
  logic             en;
  logic [PC_W-1:0]  rom_addr;
  logic [ROM_W-1:0] rom_data;
  logic             jmp;
  logic [PC_W-1:0]  jmp_addr;
  logic             halt;
  logic [OP_W-1:0]  op;
  logic [IMM_W-1:0] imm;
  logic [PC_W-1:0]  pc;
  logic             inst_valid;
  logic             halted;
  modport master (
    input  en, rom_data, jmp, jmp_addr, halt,
    output rom_addr, op, imm, pc, inst_valid, halted
  );
  modport slave (
    output en, rom_data, jmp, jmp_addr, halt,
    input  rom_addr, op, imm, pc, inst_valid, halted
  );
endinterface

// File: rtl/inst_fetch_pc_reg.sv
// inst_fetch_pc_reg: program counter with load (priority) and wrapping increment
module inst_fetch_pc_reg
  import inst_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] q
);
  // load wins over increment; increment wraps naturally at PC_W bits
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= RESET_PC;
    else if (load) q <= load_val;
    else if (inc) q <= q + 1'b1;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: three-step fetch FSM driving a synchronous ROM and holding the instruction register
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);
  state_t           state, state_n;
  logic [ROM_W-1:0] ir;
  logic [PC_W-1:0]  pc;
  logic             pc_load, pc_inc, ir_load, retire;
  inst_fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (bus.jmp_addr),
    .q        (pc)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ADDR;
    else state <= state_n;
  // next state and pc/ir strobes; jmp/halt only matter on an enabled EXEC edge, halt beats jmp
  always_comb begin
    retire  = bus.en && state == EXEC && !bus.halt;
    pc_load = retire && bus.jmp;
    pc_inc  = retire && !bus.jmp;
    ir_load = bus.en && state == WAIT;
    state_n = !bus.en        ? state :
              state == ADDR  ? WAIT  :
              state == WAIT  ? EXEC  :
              state == EXEC  ? (bus.halt ? HALT : ADDR) : HALT;
  end
  // instruction register captures the ROM word on the WAIT->EXEC edge
  always_ff @(posedge clk or posedge rst)
    if (rst) ir <= '0;
    else if (ir_load) ir <= bus.rom_data;
  assign bus.rom_addr   = pc;
  assign bus.pc         = pc;
  assign bus.op         = ir[ROM_W-1:IMM_W];
  assign bus.imm        = ir[IMM_W-1:0];
  assign bus.inst_valid = state == EXEC;
  assign bus.halted     = state == HALT;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed checks of the fetch stage against a synchronous ROM model
module tb_inst_fetch;
  import inst_fetch_pkg::*;
  logic clk = 0;
  logic rst = 1;
  int n_cmp = 0;
  int n_err = 0;
  logic [ROM_W-1:0] rom [256];
  logic [ROM_W-1:0] w;
  inst_fetch_if bus ();
  inst_fetch dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always_ff @(posedge clk) bus.rom_data <= rom[bus.rom_addr];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int k;
    for (int i = 0; i < 256; i++) rom[i] = ROM_W'(i * 7);
    rom[0] = 12'h3A5; rom[1] = 12'h712; rom[2] = 12'h134; rom[3] = 12'hC56;
    rom[4] = 12'hE0F; rom[5] = 12'h200; rom[8'h40] = 12'h999; rom[8'hFF] = 12'h555;
    bus.en = 0; bus.jmp = 0; bus.jmp_addr = 0; bus.halt = 0;
    #12;
    chk("rst_op", bus.op, 0); chk("rst_imm", bus.imm, 0); chk("rst_pc", bus.pc, 0);
    chk("rst_valid", bus.inst_valid, 0); chk("rst_halted", bus.halted, 0);
    rst = 0;
    bus.en = 1;
    step(); chk("t1_e1_valid", bus.inst_valid, 0);
    step(); chk("t1_op", bus.op, 3); chk("t1_imm", bus.imm, 8'hA5);
    chk("t1_valid", bus.inst_valid, 1); chk("t1_pc", bus.pc, 0);
    step(); chk("t1_addr", bus.rom_addr, 1); chk("t1_hold_op", bus.op, 3);
    for (int n = 1; n < 5; n++) begin
      step(); chk("t2_wait_valid", bus.inst_valid, 0);
      step(); chk("t2_valid", bus.inst_valid, 1);
      w = rom[n];
      chk("t2_op", bus.op, w[11:8]); chk("t2_pc", bus.pc, n);
      step();
    end
    bus.jmp = 1; bus.jmp_addr = 8'h40;
    step(); chk("t3_jmp_addr_ignored", bus.rom_addr, 5);
    step(); chk("t3_jmp_wait_ignored", bus.pc, 5); chk("t3_exec", bus.inst_valid, 1);
    step(); chk("t3_jump", bus.rom_addr, 8'h40);
    bus.jmp = 0;
    step(); step();
    chk("t3_op", bus.op, 9); chk("t3_imm", bus.imm, 8'h99); chk("t3_pc", bus.pc, 8'h40);
    bus.jmp = 1; bus.jmp_addr = 8'h40;
    step(); chk("t3_selfloop", bus.pc, 8'h40);
    bus.jmp_addr = 8'hFF;
    step(); step(); step(); chk("t4_jmp_ff", bus.pc, 8'hFF);
    bus.jmp = 0;
    step(); step(); chk("t4_op_ff", bus.op, 5);
    step(); chk("t4_wrap", bus.pc, 0);
    step(); step(); chk("t4_exec0", bus.op, 3);
    bus.halt = 1; bus.jmp = 1; bus.jmp_addr = 8'h40;
    step(); chk("t4_halted", bus.halted, 1); chk("t4_halt_pc", bus.pc, 0);
    chk("t4_halt_valid", bus.inst_valid, 0);
    bus.halt = 0; bus.jmp = 0;
    repeat (20) step();
    chk("t4_still_halted", bus.halted, 1); chk("t4_still_pc", bus.rom_addr, 0);
    #2 rst = 1;
    #1 chk("t4_rst_halted", bus.halted, 0);
    rst = 0;
    k = 0;
    for (int c = 0; c < 200 && k < 12; c++) begin
      bus.en = 1'($urandom_range(0, 1));
      if (bus.en) k++;
      step();
      chk("t5_valid", bus.inst_valid, (k % 3) == 2);
      chk("t5_pc", bus.pc, k / 3);
      w = k < 2 ? '0 : rom[(k - 2) / 3];
      chk("t5_op", bus.op, w[11:8]);
    end
    chk("t5_progress", k, 12);
    bus.en = 1;
    step(); chk("t6_in_wait_pc", bus.pc, 4);
    #2 rst = 1;
    #1 chk("t6_op", bus.op, 0); chk("t6_pc", bus.rom_addr, 0); chk("t6_valid", bus.inst_valid, 0);
    rst = 0;
    step(); step();
    chk("t6_refetch_op", bus.op, 3); chk("t6_refetch_imm", bus.imm, 8'hA5); chk("t6_refetch_pc", bus.pc, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
